id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between Decode (ID) and Execute (EX) of the RV32I five-stage core. Each cycle it captures the decoder control bundle, operands and register indices from ID and presents them, registered, to EX. It inserts bubbles on branch/jump flushes and on load-use hazards, and holds its contents on an external stall. It produces the stall request that freezes PC and IF/ID while a load-use bubble is inserted.

## Interface
Parameters:
- XLEN, 32, datapath width for PC, operand and immediate fields.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in, mux_ula_in, pc_ula_in, jump_in, branch_in  in  1 each  decoder control bits from ID.
- ula_op_in  in  2  ALU operation class from ID.
- pc_in, rs1_val_in, rs2_val_in, imm_in  in  XLEN each  ID datapath fields.
- rs1_in, rs2_in, rd_in  in  5 each  register indices.
- funct3_in  in  3  instruction funct3.
- funct7b5_in  in  1  instruction bit 30.
- flush_in  in  1  redirect from EX (taken branch or jump); kills the instruction entering EX.
- stall_in  in  1  external hold (e.g. data-memory wait); freezes this register.
- *_out  out  same widths  registered copies of every *_in field above.
- valid_out  out  1  EX slot holds a real instruction.
- hazard_stall_out  out  1  combinational; freezes PC and IF/ID for one cycle.

## Operation
- Update priority at each rising clk edge: rst > flush_in > stall_in > load-use bubble > normal load.
- rst: every *_out, valid_out = 0. The register holds a bubble after reset.
- flush_in = 1: load a bubble. All control outputs = 0 (incl. reg_wr_out, mem_wr_out, branch_out, jump_out), valid_out = 0, datapath and index outputs = 0.
- stall_in = 1 (no flush): all outputs keep their value.
- Load-use detect: hazard_raw = valid_out & mem_rd_out & (rd_out != 0) & ((rd_out == rs1_in) | (rd_out == rs2_in)).
- hazard_stall_out = hazard_raw & ~flush_in & ~stall_in.
- hazard_stall_out = 1: load a bubble, the same as for a flush. The ID instruction is held upstream and re-presented next cycle.
- Normal: capture all *_in, valid_out = 1.
- The rs2 compare applies to all formats (conservative). A false stall on I/U formats is accepted.

## Timing
- Latency: 1 cycle from ID inputs to *_out.
- hazard_stall_out is purely combinational from the registered EX state and the current rs1_in/rs2_in. It is valid in the same cycle and has no register stage.
- One load-use pair costs exactly one bubble. On the following cycle the load has left EX, so hazard_raw = 0, unless stall_in holds it.
- flush_in together with a hazard: flush wins and hazard_stall_out = 0.
- stall_in together with a hazard: hold wins and hazard_stall_out = 0. The hazard re-evaluates when stall_in drops.
- rst asserted mid-operation overrides everything on that edge. hazard_stall_out is 0 while outputs are in reset state (valid_out = 0).
- Back-to-back loads with no dependency: no bubble.

## Configuration
- LOAD_USE_DETECT_EN defined: the hazard logic above is compiled in.
- LOAD_USE_DETECT_EN undefined:
  - hazard_stall_out is tied to 0.
  - Bubbles come only from flush_in.
  - Software/compiler scheduling must guarantee no load-use pairs.
  - Flush and stall behaviour is unchanged.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> all outputs 0, valid_out = 0, hazard_stall_out = 0.
- Pass-through: R-type, pc_in = 0x100, rs1_val_in = 5, rs2_val_in = 7, rd_in = 3, ula_op_in = 2'b10, reg_wr_in = 1 -> next cycle the matching *_out, valid_out = 1.
- Load-use: lw x5 in EX, then add x6,x5,x1 in ID -> hazard_stall_out = 1 that cycle, a bubble next cycle (valid_out = 0, reg_wr_out = 0), the add captured the cycle after, hazard_stall_out = 0.
- x0 target: lw x0 in EX, ID reads rs1 = 0 -> hazard_stall_out = 0, no bubble.
- Flush priority: load-use condition plus flush_in = 1 -> hazard_stall_out = 0, bubble loaded, mem_wr_out = 0, jump_out = 0.
- Hold: stall_in = 1 for 3 cycles with changing inputs -> outputs frozen. With lw x5 in EX and rs1_in = 5, hazard_stall_out stays 0 during the hold and goes to 1 on the first cycle with stall_in = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Pipeline register between Decode (ID) and Execute (EX) of the
//               RV32I five-stage core. It captures the decoder control bundle,
//               operands and register indices from ID and presents them,
//               registered, to EX. It inserts bubbles on a branch/jump flush
//               and on a load-use hazard, and holds on an external stall.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   *_in                decoder control bits, ALU class, PC/operands/immediate,
//                       register indices, funct3, funct7 bit 5 from ID
//   flush_in            redirect from EX; kills the instruction entering EX
//   stall_in            external hold; freezes this register
//   *_out               registered copies of every *_in field
//   valid_out           EX slot holds a real instruction
//   hazard_stall_out    combinational; freezes PC and IF/ID for one cycle
// Configuration
//   LOAD_USE_DETECT_EN  when defined, the load-use hazard logic is compiled in.
//                       When undefined, hazard_stall_out is tied low and
//                       bubbles come only from flush_in.
// ============================================================================
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            mem_rd_in,
  input  logic            mem_wr_in,
  input  logic            reg_wr_in,
  input  logic            mux_reg_wr_in,
  input  logic            mux_ula_in,
  input  logic            pc_ula_in,
  input  logic            jump_in,
  input  logic            branch_in,
  input  logic [1:0]      ula_op_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_val_in,
  input  logic [XLEN-1:0] rs2_val_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7b5_in,
  input  logic            flush_in,
  input  logic            stall_in,

  output logic            mem_rd_out,
  output logic            mem_wr_out,
  output logic            reg_wr_out,
  output logic            mux_reg_wr_out,
  output logic            mux_ula_out,
  output logic            pc_ula_out,
  output logic            jump_out,
  output logic            branch_out,
  output logic [1:0]      ula_op_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_val_out,
  output logic [XLEN-1:0] rs2_val_out,
  output logic [XLEN-1:0] imm_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      funct3_out,
  output logic            funct7b5_out,
  output logic            valid_out,
  output logic            hazard_stall_out
);

  // Everything that travels from ID to EX, kept as one packed bundle so that
  // a bubble is simply the all-zero value.
  typedef struct packed {
    logic            mem_rd;
    logic            mem_wr;
    logic            reg_wr;
    logic            mux_reg_wr;
    logic            mux_ula;
    logic            pc_ula;
    logic            jump;
    logic            branch;
    logic [1:0]      ula_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            valid;
  } id_ex_t;

  localparam id_ex_t BUBBLE = '0;

  id_ex_t stage_q;
  id_ex_t stage_d;
  id_ex_t id_bundle;
  logic   hazard_raw;

  // Incoming instruction from ID; anything captured normally is valid.
  always_comb begin
    id_bundle            = BUBBLE;
    id_bundle.mem_rd     = mem_rd_in;
    id_bundle.mem_wr     = mem_wr_in;
    id_bundle.reg_wr     = reg_wr_in;
    id_bundle.mux_reg_wr = mux_reg_wr_in;
    id_bundle.mux_ula    = mux_ula_in;
    id_bundle.pc_ula     = pc_ula_in;
    id_bundle.jump       = jump_in;
    id_bundle.branch     = branch_in;
    id_bundle.ula_op     = ula_op_in;
    id_bundle.pc         = pc_in;
    id_bundle.rs1_val    = rs1_val_in;
    id_bundle.rs2_val    = rs2_val_in;
    id_bundle.imm        = imm_in;
    id_bundle.rs1        = rs1_in;
    id_bundle.rs2        = rs2_in;
    id_bundle.rd         = rd_in;
    id_bundle.funct3     = funct3_in;
    id_bundle.funct7b5   = funct7b5_in;
    id_bundle.valid      = 1'b1;
  end

`ifdef LOAD_USE_DETECT_EN
  // A load sitting in EX whose destination is read by the instruction in ID.
  // rs2 is compared for every format; an occasional false stall on I/U
  // formats is cheaper than decoding the format here. x0 never hazards.
  always_comb begin
    hazard_raw = stage_q.valid && stage_q.mem_rd && (stage_q.rd != 5'd0) &&
                 ((stage_q.rd == rs1_in) || (stage_q.rd == rs2_in));
  end
`else
  // Load-use pairs are excluded by software scheduling.
  always_comb begin
    hazard_raw = 1'b0;
  end
`endif

  // Flush and hold both outrank the hazard, so it is suppressed under either;
  // a held hazard re-evaluates once stall_in drops.
  always_comb begin
    hazard_stall_out = hazard_raw && !flush_in && !stall_in;
  end

  // Next-state priority below reset: flush > hold > load-use bubble > load.
  always_comb begin
    stage_d = stage_q;
    if (flush_in) begin
      stage_d = BUBBLE;
    end else if (stall_in) begin
      stage_d = stage_q;
    end else if (hazard_raw) begin
      stage_d = BUBBLE;
    end else begin
      stage_d = id_bundle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    mem_rd_out     = stage_q.mem_rd;
    mem_wr_out     = stage_q.mem_wr;
    reg_wr_out     = stage_q.reg_wr;
    mux_reg_wr_out = stage_q.mux_reg_wr;
    mux_ula_out    = stage_q.mux_ula;
    pc_ula_out     = stage_q.pc_ula;
    jump_out       = stage_q.jump;
    branch_out     = stage_q.branch;
    ula_op_out     = stage_q.ula_op;
    pc_out         = stage_q.pc;
    rs1_val_out    = stage_q.rs1_val;
    rs2_val_out    = stage_q.rs2_val;
    imm_out        = stage_q.imm;
    rs1_out        = stage_q.rs1;
    rs2_out        = stage_q.rs2;
    rd_out         = stage_q.rd;
    funct3_out     = stage_q.funct3;
    funct7b5_out   = stage_q.funct7b5;
    valid_out      = stage_q.valid;
  end

endmodule
`default_nettype wire
